// File: rtl/reset_sequencer.sv
// Reset sequencer: async assert, synchronised release, stretch, then staggered per-domain release.
// soft_reset reruns the stretch/release sequence without touching the synchroniser.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned NUM_OUTPUTS    = 3,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STEP_DELAY     = 8
) (
  input  logic                   clk,
  input  logic                   async_reset_n,
  input  logic                   soft_reset,
  output logic [NUM_OUTPUTS-1:0] sync_reset,
  output logic                   reset_done,
  output logic [1:0]             seq_state
);

  localparam int unsigned MaxCycles = (STRETCH_CYCLES > STEP_DELAY) ? STRETCH_CYCLES : STEP_DELAY;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] StretchLast = CntW'(STRETCH_CYCLES - 1);
  localparam logic [CntW-1:0] StepLast    = CntW'(STEP_DELAY - 1);

  typedef enum logic [1:0] {
    StReset   = 2'd0,
    StStretch = 2'd1,
    StRelease = 2'd2,
    StDone    = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srst;
  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [NUM_OUTPUTS-1:0] rst_q;
  logic [NUM_OUTPUTS-1:0] rst_shift;
  logic                   done_q;
  logic                   step_hit;

  // Release path synchroniser: preset to ones, shifts zeros in once reset lifts.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign srst = sync_q[SYNC_STAGES-1];

  // Outputs release in ascending index order, so a left shift clears the next bit.
  assign rst_shift = rst_q << 1;
  assign step_hit  = (cnt_q == ((state_q == StStretch) ? StretchLast : StepLast));

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q <= StReset;
      cnt_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else if (soft_reset && (state_q != StReset)) begin
      state_q <= StStretch;
      cnt_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StReset: begin
          if (!srst) begin
            state_q <= StStretch;
            cnt_q   <= '0;
          end
        end
        StStretch, StRelease: begin
          if (step_hit) begin
            cnt_q <= '0;
            rst_q <= rst_shift;
            if (rst_shift == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRelease;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
        end
        default: begin
          state_q <= StReset;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sync_reset = rst_q;
  assign reset_done = done_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal-parameter instance.
module tb_reset_sequencer;

  localparam int Stretch = 16;
  localparam int Step    = 8;

  logic       clk;
  logic       async_reset_n;
  logic       soft_reset;
  logic       soft_reset2;
  logic [2:0] sync_reset;
  logic       reset_done;
  logic [1:0] seq_state;
  logic [0:0] sync_reset2;
  logic       reset_done2;
  logic [1:0] seq_state2;

  int n_cmp;
  int n_bad;

  reset_sequencer dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .soft_reset    (soft_reset),
    .sync_reset    (sync_reset),
    .reset_done    (reset_done),
    .seq_state     (seq_state)
  );

  reset_sequencer #(
    .SYNC_STAGES    (3),
    .NUM_OUTPUTS    (1),
    .STRETCH_CYCLES (1),
    .STEP_DELAY     (8)
  ) dut_min (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .soft_reset    (soft_reset2),
    .sync_reset    (sync_reset2),
    .reset_done    (reset_done2),
    .seq_state     (seq_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_vec(input int k, input int rel0);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (k < rel0 + Step * i);
    return v;
  endfunction

  function automatic logic [1:0] exp_state(input int k, input int rel0, input int st_start);
    if (k < st_start) return 2'd0;
    if (k < rel0) return 2'd1;
    if (k < rel0 + Step * 2) return 2'd2;
    return 2'd3;
  endfunction

  // Edges first_k..last_k, numbered from the async rise (cold) or the last soft_reset sample.
  task automatic run_seq(input int first_k, input int last_k, input int rel0,
                         input int st_start, input bit cold);
    for (int k = first_k; k <= last_k; k++) begin
      tick();
      check($sformatf("sync_reset k=%0d", k), 32'(sync_reset), 32'(exp_vec(k, rel0)));
      check($sformatf("reset_done k=%0d", k), 32'(reset_done), 32'(k >= rel0 + Step * 2));
      check($sformatf("seq_state k=%0d", k), 32'(seq_state), 32'(exp_state(k, rel0, st_start)));
      if (cold) begin
        check($sformatf("min sync_reset k=%0d", k), 32'(sync_reset2), 32'(k < 5));
        check($sformatf("min reset_done k=%0d", k), 32'(reset_done2), 32'(k >= 5));
        check($sformatf("min seq_state k=%0d", k), 32'(seq_state2),
              32'((k < 4) ? 0 : (k < 5) ? 1 : 3));
      end
    end
  endtask

  // Called at posedge+1; low pulse of 2 ns ending on the following negedge.
  task automatic async_pulse(input string tag);
    #2;
    async_reset_n = 1'b0;
    #1;
    check({tag, " sync_reset"}, 32'(sync_reset), 32'h7);
    check({tag, " reset_done"}, 32'(reset_done), 32'h0);
    check({tag, " seq_state"}, 32'(seq_state), 32'h0);
    check({tag, " min sync_reset"}, 32'(sync_reset2), 32'h1);
    #1;
    async_reset_n = 1'b1;
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    async_reset_n = 1'b0;
    soft_reset    = 1'b0;
    soft_reset2   = 1'b0;

    // Cold start: held low for 5 cycles, released on a negedge.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("low sync_reset", 32'(sync_reset), 32'h7);
      check("low reset_done", 32'(reset_done), 32'h0);
      check("low seq_state", 32'(seq_state), 32'h0);
      check("low min sync_reset", 32'(sync_reset2), 32'h1);
    end
    #4;
    async_reset_n = 1'b1;
    run_seq(1, 40, 3 + Stretch, 3, 1'b1);

    // Async pulse while in DONE, then full rerun.
    async_pulse("done pulse");
    run_seq(1, 40, 3 + Stretch, 3, 1'b1);

    // One-cycle soft reset in DONE.
    soft_reset = 1'b1;
    tick();
    check("soft S sync_reset", 32'(sync_reset), 32'h7);
    check("soft S reset_done", 32'(reset_done), 32'h0);
    check("soft S seq_state", 32'(seq_state), 32'h1);
    soft_reset = 1'b0;
    run_seq(1, 20, Stretch, 0, 1'b0);

    // Soft reset held 10 cycles while in RELEASE with bit 0 already released.
    soft_reset = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check($sformatf("soft hold sync_reset j=%0d", j), 32'(sync_reset), 32'h7);
      check($sformatf("soft hold seq_state j=%0d", j), 32'(seq_state), 32'h1);
      check($sformatf("soft hold reset_done j=%0d", j), 32'(reset_done), 32'h0);
    end
    soft_reset = 1'b0;
    run_seq(1, 36, Stretch, 0, 1'b0);

    // Async assertion mid-STRETCH (counter at 7 after edge 10), then cold-identical timing.
    async_pulse("pre pulse");
    run_seq(1, 10, 3 + Stretch, 3, 1'b1);
    async_pulse("stretch pulse");
    run_seq(1, 40, 3 + Stretch, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
